// File: rtl/amo_rmw_sequencer_if.sv
// AMO read-modify-write sequencer bus: agent request side, memory port and
// atomic ALU hookup. The sequencer uses the master modport; the surrounding
// agents, memory and ALU use the slave modport.
package amo_rmw_sequencer_pkg;

  typedef enum logic [3:0] {
    AMO_ADD  = 4'd0,
    AMO_SWAP = 4'd1,
    AMO_XOR  = 4'd2,
    AMO_AND  = 4'd3,
    AMO_OR   = 4'd4,
    AMO_MIN  = 4'd5,
    AMO_MAX  = 4'd6,
    AMO_MINU = 4'd7,
    AMO_MAXU = 4'd8
  } amo_t;

endpackage

interface amo_rmw_sequencer_if #(
  parameter int unsigned NUM_UNITS = 3
);
  import amo_rmw_sequencer_pkg::*;

  // Agent side
  logic [NUM_UNITS-1:0] req;
  amo_t                 op   [NUM_UNITS];
  logic [31:0]          addr [NUM_UNITS];
  logic [31:0]          rs2  [NUM_UNITS];
  logic [NUM_UNITS-1:0] grant;
  logic [NUM_UNITS-1:0] done;
  logic [31:0]          rd;

  // Memory port
  logic                 mem_req;
  logic                 mem_we;
  logic [31:0]          mem_addr;
  logic [31:0]          mem_wdata;
  logic                 mem_ack;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;

  // Atomic ALU and reservation clear
  amo_t                 alu_op;
  logic [31:0]          alu_rs1;
  logic [31:0]          alu_rs2;
  logic [31:0]          alu_rd;
  logic                 clear_reservation;

  modport master (
    input  req, op, addr, rs2,
    output grant, done, rd,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rvalid, mem_rdata,
    output alu_op, alu_rs1, alu_rs2,
    input  alu_rd,
    output clear_reservation
  );

  modport slave (
    output req, op, addr, rs2,
    input  grant, done, rd,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rvalid, mem_rdata,
    input  alu_op, alu_rs1, alu_rs2,
    output alu_rd,
    input  clear_reservation
  );

endinterface

// File: rtl/amo_rmw_sequencer.sv
// amo_rmw_sequencer: arbitrates AMO requests and runs one read / ALU /
// write-back transaction at a time against the memory port.
// Optional feature macro: AMO_RR_ARBITRATION_EN selects round-robin
// arbitration; when undefined the lowest requesting index wins.
module amo_rmw_sequencer
  import amo_rmw_sequencer_pkg::*;
#(
  parameter int unsigned NUM_UNITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  amo_rmw_sequencer_if.master bus
);

  localparam int unsigned IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ      = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [NUM_UNITS-1:0] grant_q, grant_d;
  logic [NUM_UNITS-1:0] done_q, done_d;
  logic [31:0]          rd_q, rd_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          rs2_q, rs2_d;
  logic [31:0]          old_q, old_d;
  amo_t                 op_q, op_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand;

`ifdef AMO_RR_ARBITRATION_EN
  logic [IDX_W-1:0]     ptr_q;

  // Round-robin winner: first requester at or after the pointer
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NUM_UNITS);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Pointer moves just past each winner
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (state_q == S_IDLE && win_found) begin
      ptr_q <= (32'(win_idx) + 32'd1 >= NUM_UNITS) ? '0 : IDX_W'(32'(win_idx) + 32'd1);
    end
  end
`else
  // Fixed priority winner: lowest requesting index
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_UNITS; k++) begin
      cand = IDX_W'(k);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end
`endif

  // Next-state and next-output decode for the RMW sequence
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    done_d    = '0;
    rd_d      = rd_q;
    addr_d    = addr_q;
    rs2_d     = rs2_q;
    old_d     = old_q;
    op_d      = op_q;
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d   = S_READ;
          grant_d   = NUM_UNITS'(1) << win_idx;
          op_d      = bus.op[win_idx];
          addr_d    = bus.addr[win_idx];
          rs2_d     = bus.rs2[win_idx];
          mem_req_d = 1'b1;
        end
      end
      S_READ: begin
        if (bus.mem_ack) begin
          state_d = S_WAIT_DATA;
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_WAIT_DATA: begin
        if (bus.mem_rvalid) begin
          old_d     = bus.mem_rdata;
          state_d   = S_WRITE;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end
      end
      S_WRITE: begin
        if (bus.mem_ack) begin
          state_d = S_DONE;
          done_d  = grant_q;
          rd_d    = old_q;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      rd_q      <= '0;
      addr_q    <= '0;
      rs2_q     <= '0;
      old_q     <= '0;
      op_q      <= AMO_ADD;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      addr_q    <= addr_d;
      rs2_q     <= rs2_d;
      old_q     <= old_d;
      op_q      <= op_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.rd        = rd_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.alu_op    = op_q;
  assign bus.alu_rs1   = old_q;
  assign bus.alu_rs2   = rs2_q;

  // Write data comes straight from the ALU; its inputs are latched, so it
  // holds steady while the write waits for acceptance.
  assign bus.mem_wdata = (state_q == S_WRITE) ? bus.alu_rd : '0;

  // Reservation clear fires in the cycle the write-back is accepted
  assign bus.clear_reservation = (state_q == S_WRITE) && bus.mem_ack;

endmodule

// File: tb/tb_amo_rmw_sequencer.sv
// Testbench for amo_rmw_sequencer: directed scenarios followed by a
// randomized phase, checked against a transaction-level reference model.
module tb_amo_rmw_sequencer;
  import amo_rmw_sequencer_pkg::*;

  localparam int NU = 3;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  int unsigned rd_delay = 0;
  int unsigned wr_delay = 0;

  logic [31:0] phys  [int unsigned];
  logic [31:0] model [int unsigned];
  int          rr_next = 0;

  int          exp_w;
  logic [31:0] exp_old, exp_new, exp_addr;

  amo_rmw_sequencer_if #(.NUM_UNITS(NU)) bus ();

  amo_rmw_sequencer #(.NUM_UNITS(NU)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(input amo_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      AMO_ADD:  return a + b;
      AMO_SWAP: return b;
      AMO_XOR:  return a ^ b;
      AMO_AND:  return a & b;
      AMO_OR:   return a | b;
      AMO_MIN:  return ($signed(a) < $signed(b)) ? a : b;
      AMO_MAX:  return ($signed(a) > $signed(b)) ? a : b;
      AMO_MINU: return (a < b) ? a : b;
      AMO_MAXU: return (a > b) ? a : b;
      default:  return b;
    endcase
  endfunction

  // Combinational atomic ALU attached to the sequencer
  assign bus.alu_rd = alu_ref(bus.alu_op, bus.alu_rs1, bus.alu_rs2);

  function automatic logic [31:0] phys_get(input logic [31:0] a);
    if (phys.exists(a)) return phys[a];
    return 32'd0;
  endfunction

  function automatic logic [31:0] model_get(input logic [31:0] a);
    if (model.exists(a)) return model[a];
    return 32'd0;
  endfunction

  function automatic int pick(input logic [NU-1:0] r);
`ifdef AMO_RR_ARBITRATION_EN
    for (int k = 0; k < NU; k++) begin
      int c;
      c = (rr_next + k) % NU;
      if (r[c]) return c;
    end
`else
    for (int k = 0; k < NU; k++) begin
      if (r[k]) return k;
    end
`endif
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_agent(input int a, input amo_t op, input logic [31:0] ad, input logic [31:0] r2);
    bus.op[a]   = op;
    bus.addr[a] = ad;
    bus.rs2[a]  = r2;
  endtask

  task automatic rand_agent(input int a);
    set_agent(a, amo_t'(4'($urandom_range(0, 8))),
              32'h400 + 32'(4 * $urandom_range(0, 7)), 32'($urandom));
  endtask

  // Predict the next completed transaction from the current request vector
  task automatic expect_next();
    exp_w = pick(bus.req);
    if (exp_w < 0) exp_w = 0;
    exp_addr = bus.addr[exp_w];
    exp_old  = model_get(exp_addr);
    exp_new  = alu_ref(bus.op[exp_w], exp_old, bus.rs2[exp_w]);
    model[exp_addr] = exp_new;
    rr_next = (exp_w + 1) % NU;
  endtask

  // Wait (bounded) for done and compare against the prediction
  task automatic wait_done(input string tag, input int exp_lat, input int exp_cr);
    int cyc;
    int cr_n;
    int cr_at;
    bit got;
    cyc = 0; cr_n = 0; cr_at = -1; got = 1'b0;
    while (!got && cyc < 200) begin
      tick();
      cyc++;
      if (bus.clear_reservation) begin
        cr_n++;
        cr_at = cyc;
      end
      if (bus.done != '0) got = 1'b1;
    end
    chk({tag, "_seen"}, 32'(got), 32'd1);
    chk({tag, "_done"}, 32'(bus.done), 32'd1 << exp_w);
    chk({tag, "_grant"}, 32'(bus.grant), 32'd1 << exp_w);
    chk({tag, "_rd"}, bus.rd, exp_old);
    chk({tag, "_mem"}, phys_get(exp_addr), exp_new);
    chk({tag, "_clr_cnt"}, 32'(cr_n), 32'd1);
    if (exp_lat >= 0) chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    if (exp_cr >= 0) chk({tag, "_clr_cyc"}, 32'(cr_at), 32'(exp_cr));
  endtask

  // Memory responder with programmable ack delay; rvalid the cycle after a read ack
  initial begin : mem_responder
    int unsigned wait_cnt;
    bit          pend;
    logic [31:0] paddr;
    logic [31:0] s_addr, s_wdata;
    logic        s_we;
    wait_cnt = 0; pend = 1'b0; paddr = '0;
    s_addr = '0; s_wdata = '0; s_we = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_ack    = 1'b0;
      bus.mem_rvalid = 1'b0;
      if (rst) begin
        wait_cnt = 0;
        pend     = 1'b0;
      end else if (pend) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = phys_get(paddr);
        pend           = 1'b0;
      end else if (bus.mem_req) begin
        if (wait_cnt == 0) begin
          s_addr = bus.mem_addr; s_we = bus.mem_we; s_wdata = bus.mem_wdata;
        end else begin
          chk("hold_addr", bus.mem_addr, s_addr);
          chk("hold_we", 32'(bus.mem_we), 32'(s_we));
          chk("hold_wdata", bus.mem_wdata, s_wdata);
        end
        if (wait_cnt == (bus.mem_we ? wr_delay : rd_delay)) begin
          bus.mem_ack = 1'b1;
          wait_cnt    = 0;
          if (bus.mem_we) begin
            phys[bus.mem_addr] = bus.mem_wdata;
          end else begin
            pend  = 1'b1;
            paddr = bus.mem_addr;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int order [4];
    rst = 1'b1;
    bus.req = '0;
    for (int i = 0; i < NU; i++) set_agent(i, AMO_ADD, 32'd0, 32'd0);
    repeat (3) tick();

    // Reset state
    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_clr", 32'(bus.clear_reservation), 32'd0);
    chk("rst_rd", bus.rd, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
    chk("rst_alu_rs1", bus.alu_rs1, 32'd0);
    chk("rst_alu_rs2", bus.alu_rs2, 32'd0);
    rst = 1'b0;

    // Single agent add, zero-wait memory
    phys[32'h100] = 32'd5; model[32'h100] = 32'd5;
    set_agent(0, AMO_ADD, 32'h100, 32'd3);
    bus.req = 3'b001;
    expect_next();
    wait_done("add", 4, 3);
    chk("add_mem8", phys_get(32'h100), 32'd8);
    chk("add_rd5", bus.rd, 32'd5);
    bus.req = '0;
    tick();
    chk("add_done_pulse", 32'(bus.done), 32'd0);
    chk("add_grant_clr", 32'(bus.grant), 32'd0);

    // Swap
    phys[32'h40] = 32'hDEAD; model[32'h40] = 32'hDEAD;
    set_agent(0, AMO_SWAP, 32'h40, 32'hBEEF);
    bus.req = 3'b001;
    expect_next();
    wait_done("swap", 4, 3);
    chk("swap_mem", phys_get(32'h40), 32'hBEEF);
    chk("swap_rd", bus.rd, 32'hDEAD);
    bus.req = '0;
    tick();

    // Three agents keep requesting from a fresh reset
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    rr_next = 0;
`ifdef AMO_RR_ARBITRATION_EN
    order = '{1, 2, 4, 1};
`else
    order = '{1, 1, 1, 1};
`endif
    for (int i = 0; i < NU; i++) set_agent(i, AMO_ADD, 32'h200 + 32'(4 * i), 32'(i + 1));
    bus.req = 3'b111;
    for (int n = 0; n < 4; n++) begin
      expect_next();
      wait_done("arb", (n == 0) ? 4 : 5, (n == 0) ? 3 : 4);
      chk("arb_order", 32'(bus.grant), 32'(order[n]));
    end
    bus.req = '0;
    tick();
    chk("arb_idle_grant", 32'(bus.grant), 32'd0);

    // Ack delayed 3 cycles on both read and write
    rd_delay = 3; wr_delay = 3;
    phys[32'h80] = 32'h12345678; model[32'h80] = 32'h12345678;
    set_agent(0, AMO_XOR, 32'h80, 32'hFF00FF00);
    bus.req = 3'b001;
    expect_next();
    wait_done("delay", 10, 9);
    bus.req = '0;
    rd_delay = 0; wr_delay = 0;
    tick();

    // Reset while waiting for read data
    phys[32'h90] = 32'h10; model[32'h90] = 32'h10;
    set_agent(0, AMO_OR, 32'h90, 32'hF);
    bus.req = 3'b001;
    tick(); tick();
    chk("rstw_grant", 32'(bus.grant), 32'd1);
    chk("rstw_mem_req", 32'(bus.mem_req), 32'd0);
    rst = 1'b1;
    bus.req = '0;
    tick();
    chk("rstw_grant0", 32'(bus.grant), 32'd0);
    chk("rstw_mem_req0", 32'(bus.mem_req), 32'd0);
    chk("rstw_mem_we0", 32'(bus.mem_we), 32'd0);
    chk("rstw_done0", 32'(bus.done), 32'd0);
    chk("rstw_rs1_0", bus.alu_rs1, 32'd0);
    chk("rstw_rd0", bus.rd, 32'd0);
    rst = 1'b0;
    rr_next = 0;
    repeat (3) begin
      tick();
      chk("rstw_no_done", 32'(bus.done), 32'd0);
    end
    chk("rstw_mem_untouched", phys_get(32'h90), 32'h10);
    bus.req = 3'b001;
    expect_next();
    wait_done("post_rst", 4, 3);
    chk("post_rst_mem", phys_get(32'h90), 32'h1F);
    bus.req = '0;
    tick();

    // Agent 1 drops req during write-back; agent 2 waits
    phys[32'h304] = 32'h66; model[32'h304] = 32'h66;
    set_agent(1, AMO_SWAP, 32'h300, 32'h11111111);
    set_agent(2, AMO_MAXU, 32'h304, 32'h55);
    wr_delay = 2;
    bus.req = 3'b110;
    expect_next();
    tick(); tick(); tick();
    chk("drop_in_write", 32'(bus.mem_we), 32'd1);
    chk("drop_grant", 32'(bus.grant), 32'd2);
    bus.req[1] = 1'b0;
    wait_done("drop", 3, 2);
    chk("drop_done1", 32'(bus.done), 32'd2);
    wr_delay = 0;
    expect_next();
    wait_done("waiting", 5, 4);
    chk("waiting_done2", 32'(bus.done), 32'd4);

    // Randomized traffic, each round starting from the previous done cycle
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) rand_agent(exp_w);
      else bus.req[exp_w] = 1'b0;
      for (int a = 0; a < NU; a++) begin
        if (!bus.req[a] && $urandom_range(0, 1) == 1) begin
          rand_agent(a);
          bus.req[a] = 1'b1;
        end
      end
      if (bus.req == '0) begin
        int a;
        a = int'($urandom_range(0, NU - 1));
        rand_agent(a);
        bus.req[a] = 1'b1;
      end
      rd_delay = $urandom_range(0, 2);
      wr_delay = $urandom_range(0, 2);
      expect_next();
      wait_done("rand", int'(5 + rd_delay + wr_delay), int'(4 + rd_delay + wr_delay));
    end
    bus.req = '0;
    tick(); tick();
    chk("end_idle_grant", 32'(bus.grant), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
